instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch/issue unit. It drives the 3-bit opcode into the control unit and consumes that unit's BranchEn decision.
- It sequences the PC, requests 9-bit instructions from instruction memory over a valid handshake, and presents one instruction per execute slot.
- It resolves beq using BranchEn and the ALU Zero flag, and signals Ack when the program reaches the halt address.

Parameters:
- PC_W, 10, PC and instruction-address width.
- IW, 9, instruction width; Op = Inst[8:6], Operand = Inst[5:0].
- HALT_PC, 10'h3FF, address at which execution ends (this address is never fetched).
- CNT_W, 16, cycle-counter width.

Ports:
- Clk  in  1  single clock; all state changes on the rising edge.
- Reset  in  1  one clock; reset is synchronous and active-low (0 = reset, sampled on Clk rising edge).
- Start  in  1  begin execution from StartAddr; honoured in IDLE or DONE only.
- StartAddr  in  PC_W  initial PC.
- IMemReq  out  1  instruction fetch request.
- IMemAddr  out  PC_W  fetch address (= PC).
- IMemData  in  IW  returned instruction.
- IMemValid  in  1  IMemData valid this cycle.
- Op  out  3  opcode to the control unit.
- Operand  out  6  Inst[5:0] to the register file and branch LUT.
- InstValid  out  1  execute strobe; downstream write enables are qualified by it.
- Stall  in  1  hold the current execute slot (e.g. data memory busy).
- BranchEn  in  1  from the control unit (high for beq).
- Zero  in  1  ALU equality flag.
- BranchOffset  in  PC_W  signed two's-complement PC offset from the branch LUT.
- PC  out  PC_W  current PC.
- Ack  out  1  program complete.
- CycleCount  out  CNT_W  cycles from Start to Ack.

Behaviour:
- Reset (Reset=0 at an edge): state IDLE, PC=0, IR=0, IMemReq=0, InstValid=0, Ack=0, CycleCount=0.
- While in reset: Op=0 and Operand=0.
- Op and Operand are always IR[8:6] and IR[5:0], registered.
- States: IDLE, FETCH, EXEC, DONE.
- IDLE: when Start=1, set PC<=StartAddr and CycleCount<=0.
  - If StartAddr==HALT_PC, go to DONE.
  - Otherwise go to FETCH.
- FETCH: IMemReq=1 and IMemAddr=PC, held until IMemValid=1.
  - On IMemValid=1, IR<=IMemData and go to EXEC.
  - Minimum request-to-EXEC latency is 1 cycle; arbitrary wait states are legal.
- EXEC: InstValid = !Stall. If Stall=1, hold IR, PC and state.
  - When Stall=0, compute nextPC at the edge:
  - If BranchEn&Zero: nextPC = PC + BranchOffset, modulo 2^PC_W.
  - Otherwise: nextPC = PC + 1, modulo 2^PC_W (PC wraps 2^PC_W-1 to 0).
  - Then set PC<=nextPC. If nextPC==HALT_PC go to DONE, else go to FETCH.
- Issue rate: one instruction per 2 cycles with zero-wait memory and no stalls.
- DONE: Ack=1, IMemReq=0, InstValid=0, PC holds.
  - Start=1 restarts exactly as from IDLE, and Ack drops the next cycle.
- CycleCount increments every cycle in FETCH and EXEC and saturates at all-ones. It holds in IDLE and DONE.
- Start is ignored in FETCH and EXEC.
- IMemValid outside FETCH is ignored; a late response after a reset is discarded.
- BranchEn and Zero are sampled only at an unstalled EXEC edge.
- Reset mid-FETCH or mid-EXEC: the next state is IDLE with all reset values. The interrupted instruction is never strobed.
- Branch with BranchEn=1, Zero=0 behaves as PC+1.
- Branch offset 0 makes a legal self-loop, re-fetching the same PC.

Test Plan:
- Reset=0 for 2 cycles, then 1 → IMemReq=0, Ack=0, PC=0, Op=0, CycleCount=0.
- Start with StartAddr=0x010, memory returns 9'b000_000101 with zero wait → IMemAddr=0x010; EXEC has Op=3'b000, Operand=6'h05, InstValid=1 for one cycle; then PC=0x011 and re-fetch.
- beq at PC=0x020: IMemData=9'b101_000011, BranchEn=1, Zero=1, BranchOffset=-4 (0x3FC) → PC=0x01C.
  - Repeat with Zero=0 → PC=0x021.
- Memory inserts 3 wait cycles, then Stall=1 for 2 EXEC cycles → IMemReq held 4 cycles; InstValid=0 while stalled; exactly one InstValid pulse; CycleCount advances 7 for that instruction.
- Straight-line program from StartAddr=0x3FD, HALT_PC=0x3FF → two instructions issued, then Ack=1 with CycleCount=4.
  - Start again with StartAddr=0x3FF → DONE directly with CycleCount=0.
  - Separately, with HALT_PC=0x000 and StartAddr=0x3FF, PC wraps to 0x000 and Ack=1.
- Reset asserted during FETCH with IMemValid=1 arriving the same and next cycle → IDLE, IR=0, no InstValid pulse, stray response ignored.

Source files
------------

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch
//  Description : Instruction fetch/issue unit. Sequences the PC, fetches
//                instructions over a valid handshake, presents one
//                instruction per execute slot, resolves beq and flags
//                completion when the PC reaches HALT_PC.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch #(
  parameter int unsigned     PC_W    = 10,
  parameter int unsigned     IW      = 9,
  parameter logic [PC_W-1:0] HALT_PC = 10'h3FF,
  parameter int unsigned     CNT_W   = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [PC_W-1:0]  StartAddr,
  output logic             IMemReq,
  output logic [PC_W-1:0]  IMemAddr,
  input  logic [IW-1:0]    IMemData,
  input  logic             IMemValid,
  output logic [2:0]       Op,
  output logic [5:0]       Operand,
  output logic             InstValid,
  input  logic             Stall,
  input  logic             BranchEn,
  input  logic             Zero,
  input  logic [PC_W-1:0]  BranchOffset,
  output logic [PC_W-1:0]  PC,
  output logic             Ack,
  output logic [CNT_W-1:0] CycleCount
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [IW-1:0]    ir_q, ir_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  next_pc;
  logic [CNT_W-1:0] cnt_sat_inc;

  // Branch target / sequential PC and saturating cycle-count increment.
  // The offset is two's complement, so a plain modulo add handles both
  // directions and the wrap from the top of the address space.
  always_comb begin
    next_pc     = (BranchEn && Zero) ? (pc_q + BranchOffset) : (pc_q + PC_W'(1));
    cnt_sat_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : (cnt_q + CNT_W'(1));
  end

  // Next-state logic for the IDLE/FETCH/EXEC/DONE sequencer.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Start) begin
          pc_d    = StartAddr;
          cnt_d   = '0;
          state_d = (StartAddr == HALT_PC) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: begin
        cnt_d = cnt_sat_inc;
        if (IMemValid) begin
          ir_d    = IMemData;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_sat_inc;
        // A stalled slot holds IR, PC and state; branch inputs are only
        // consumed on the edge that retires the instruction.
        if (!Stall) begin
          pc_d    = next_pc;
          state_d = (next_pc == HALT_PC) ? S_DONE : S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; a response arriving
  // on the reset edge is dropped because reset takes priority.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are decoded from registered state only, except the execute
  // strobe which must drop in the same cycle Stall rises.
  always_comb begin
    IMemReq    = (state_q == S_FETCH);
    IMemAddr   = pc_q;
    Op         = ir_q[IW-1 -: 3];
    Operand    = ir_q[5:0];
    InstValid  = (state_q == S_EXEC) && !Stall;
    PC         = pc_q;
    Ack        = (state_q == S_DONE);
    CycleCount = cnt_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch
//  Description : Directed self-checking bench for instr_fetch with a
//                scoreboard of expected execute-slot contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

  logic       Clk;
  logic       Reset;
  logic       Start;
  logic [9:0] StartAddr;
  logic       IMemReq;
  logic [9:0] IMemAddr;
  logic [8:0] IMemData;
  logic       IMemValid;
  logic [2:0] Op;
  logic [5:0] Operand;
  logic       InstValid;
  logic       Stall;
  logic       BranchEn;
  logic       Zero;
  logic [9:0] BranchOffset;
  logic [9:0] PC;
  logic       Ack;
  logic [15:0] CycleCount;

  // Second instance with HALT_PC at zero for the wrap-around case.
  logic       Start2;
  logic       IMemValid2;
  logic       IMemReq2;
  logic [9:0] IMemAddr2;
  logic [2:0] Op2;
  logic [5:0] Operand2;
  logic       InstValid2;
  logic [9:0] PC2;
  logic       Ack2;
  logic [15:0] CycleCount2;

  int compared;
  int mismatched;

  typedef struct packed {
    logic [2:0] op;
    logic [5:0] opnd;
    logic [9:0] pc;
  } exp_t;

  exp_t sb[$];

  instr_fetch #(.PC_W(10), .IW(9), .HALT_PC(10'h3FF), .CNT_W(16)) u_dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .StartAddr(StartAddr),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemData(IMemData),
    .IMemValid(IMemValid), .Op(Op), .Operand(Operand), .InstValid(InstValid),
    .Stall(Stall), .BranchEn(BranchEn), .Zero(Zero),
    .BranchOffset(BranchOffset), .PC(PC), .Ack(Ack), .CycleCount(CycleCount)
  );

  instr_fetch #(.PC_W(10), .IW(9), .HALT_PC(10'h000), .CNT_W(16)) u_dut_wrap (
    .Clk(Clk), .Reset(Reset), .Start(Start2), .StartAddr(StartAddr),
    .IMemReq(IMemReq2), .IMemAddr(IMemAddr2), .IMemData(IMemData),
    .IMemValid(IMemValid2), .Op(Op2), .Operand(Operand2),
    .InstValid(InstValid2), .Stall(Stall), .BranchEn(BranchEn), .Zero(Zero),
    .BranchOffset(BranchOffset), .PC(PC2), .Ack(Ack2),
    .CycleCount(CycleCount2)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Runs one instruction starting from the first FETCH cycle (at a negedge).
  task automatic do_instr(input logic [9:0] pc, input logic [8:0] data,
                          input int waits, input int stalls,
                          input logic ben, input logic zero,
                          input logic [9:0] off, input logic [9:0] npc);
    int   req_cycles;
    exp_t e;
    req_cycles = 0;
    check("fetch_addr", {22'd0, IMemAddr}, {22'd0, pc});
    for (int i = 0; i < waits; i++) begin
      if (IMemReq === 1'b1) req_cycles++;
      check("wait_no_strobe", {31'd0, InstValid}, 32'd0);
      @(negedge Clk);
    end
    if (IMemReq === 1'b1) req_cycles++;
    check("req_held", req_cycles, waits + 1);
    IMemData  = data;
    IMemValid = 1'b1;
    Stall     = (stalls > 0);
    e.op   = data[8:6];
    e.opnd = data[5:0];
    e.pc   = pc;
    sb.push_back(e);
    @(negedge Clk);
    IMemValid = 1'b0;
    IMemData  = 9'h1FF;
    for (int i = 0; i < stalls; i++) begin
      check("stall_no_strobe", {31'd0, InstValid}, 32'd0);
      check("stall_pc_hold", {22'd0, PC}, {22'd0, pc});
      @(negedge Clk);
    end
    Stall        = 1'b0;
    BranchEn     = ben;
    Zero         = zero;
    BranchOffset = off;
    #1;
    check("exec_strobe", {31'd0, InstValid}, 32'd1);
    e = sb.pop_front();
    check("exec_op", {29'd0, Op}, {29'd0, e.op});
    check("exec_operand", {26'd0, Operand}, {26'd0, e.opnd});
    check("exec_pc", {22'd0, PC}, {22'd0, e.pc});
    @(negedge Clk);
    BranchEn     = 1'b0;
    Zero         = 1'b0;
    BranchOffset = 10'd0;
    check("next_pc", {22'd0, PC}, {22'd0, npc});
    check("single_strobe", {31'd0, InstValid}, 32'd0);
  endtask

  initial begin
    logic [15:0] c0;
    compared     = 0;
    mismatched   = 0;
    Reset        = 1'b0;
    Start        = 1'b0;
    StartAddr    = 10'd0;
    IMemData     = 9'd0;
    IMemValid    = 1'b0;
    Stall        = 1'b0;
    BranchEn     = 1'b0;
    Zero         = 1'b0;
    BranchOffset = 10'd0;
    Start2       = 1'b0;
    IMemValid2   = 1'b0;

    // Reset held two cycles.
    @(negedge Clk);
    check("rst_op_in_reset", {29'd0, Op}, 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    check("rst_req", {31'd0, IMemReq}, 32'd0);
    check("rst_ack", {31'd0, Ack}, 32'd0);
    check("rst_pc", {22'd0, PC}, 32'd0);
    check("rst_op", {29'd0, Op}, 32'd0);
    check("rst_operand", {26'd0, Operand}, 32'd0);
    check("rst_cnt", {16'd0, CycleCount}, 32'd0);
    check("rst_strobe", {31'd0, InstValid}, 32'd0);

    // Start at 0x010, straight-line instruction, zero-wait memory.
    Start = 1'b1; StartAddr = 10'h010;
    @(negedge Clk);
    Start = 1'b0;
    check("start_req", {31'd0, IMemReq}, 32'd1);
    do_instr(10'h010, 9'b000_000101, 0, 0, 1'b0, 1'b0, 10'h000, 10'h011);
    check("refetch_req", {31'd0, IMemReq}, 32'd1);

    // Taken forward branch to reach 0x020, then the beq cases.
    do_instr(10'h011, 9'b101_000011, 0, 0, 1'b1, 1'b1, 10'h00F, 10'h020);
    do_instr(10'h020, 9'b101_000011, 0, 0, 1'b1, 1'b1, 10'h3FC, 10'h01C);
    do_instr(10'h01C, 9'b101_000001, 0, 0, 1'b1, 1'b1, 10'h004, 10'h020);
    do_instr(10'h020, 9'b101_000011, 0, 0, 1'b1, 1'b0, 10'h3FC, 10'h021);
    // Offset zero: self-loop re-fetching the same PC.
    do_instr(10'h021, 9'b101_000000, 0, 0, 1'b1, 1'b1, 10'h000, 10'h021);
    // Zero without BranchEn is sequential.
    do_instr(10'h021, 9'b110_001010, 0, 0, 1'b0, 1'b1, 10'h3FC, 10'h022);

    // Three wait states, two stall cycles; Start asserted throughout is ignored.
    c0 = CycleCount;
    Start = 1'b1; StartAddr = 10'h100;
    do_instr(10'h022, 9'b011_110001, 3, 2, 1'b0, 1'b0, 10'h000, 10'h023);
    Start = 1'b0;
    check("wait_stall_cnt", {16'd0, CycleCount}, {16'd0, c0 + 16'd7});

    // Reset during FETCH with a response on the reset edge and the next one.
    Reset = 1'b0; IMemValid = 1'b1; IMemData = 9'b111_111111;
    @(negedge Clk);
    check("midrst_strobe", {31'd0, InstValid}, 32'd0);
    check("midrst_req", {31'd0, IMemReq}, 32'd0);
    check("midrst_op", {29'd0, Op}, 32'd0);
    Reset = 1'b1;
    @(negedge Clk);
    IMemValid = 1'b0;
    check("stray_req", {31'd0, IMemReq}, 32'd0);
    check("stray_strobe", {31'd0, InstValid}, 32'd0);
    check("stray_op", {29'd0, Op}, 32'd0);
    check("stray_operand", {26'd0, Operand}, 32'd0);
    check("stray_pc", {22'd0, PC}, 32'd0);
    check("stray_cnt", {16'd0, CycleCount}, 32'd0);

    // Program running into HALT_PC.
    Start = 1'b1; StartAddr = 10'h3FD;
    @(negedge Clk);
    Start = 1'b0;
    check("halt_start_cnt", {16'd0, CycleCount}, 32'd0);
    do_instr(10'h3FD, 9'b001_000001, 0, 0, 1'b0, 1'b0, 10'h000, 10'h3FE);
    do_instr(10'h3FE, 9'b010_000010, 0, 0, 1'b0, 1'b0, 10'h000, 10'h3FF);
    check("halt_ack", {31'd0, Ack}, 32'd1);
    check("halt_cnt", {16'd0, CycleCount}, 32'd4);
    check("halt_req", {31'd0, IMemReq}, 32'd0);
    @(negedge Clk);
    check("done_ack_hold", {31'd0, Ack}, 32'd1);
    check("done_pc_hold", {22'd0, PC}, 32'h3FF);
    check("done_cnt_hold", {16'd0, CycleCount}, 32'd4);

    // Start at HALT_PC goes straight back to DONE.
    Start = 1'b1; StartAddr = 10'h3FF;
    @(negedge Clk);
    Start = 1'b0;
    check("direct_done_ack", {31'd0, Ack}, 32'd1);
    check("direct_done_cnt", {16'd0, CycleCount}, 32'd0);
    check("direct_done_req", {31'd0, IMemReq}, 32'd0);

    // Restart from DONE drops Ack next cycle.
    Start = 1'b1; StartAddr = 10'h040;
    @(negedge Clk);
    Start = 1'b0;
    check("restart_ack", {31'd0, Ack}, 32'd0);
    check("restart_req", {31'd0, IMemReq}, 32'd1);
    check("restart_addr", {22'd0, IMemAddr}, 32'h040);

    // HALT_PC = 0: executing 0x3FF wraps PC to 0 and completes.
    Start2 = 1'b1; StartAddr = 10'h3FF;
    @(negedge Clk);
    Start2 = 1'b0;
    check("wrap_req", {31'd0, IMemReq2}, 32'd1);
    check("wrap_addr", {22'd0, IMemAddr2}, 32'h3FF);
    IMemValid2 = 1'b1; IMemData = 9'b011_000111;
    @(negedge Clk);
    IMemValid2 = 1'b0;
    check("wrap_strobe", {31'd0, InstValid2}, 32'd1);
    check("wrap_op", {29'd0, Op2}, 32'd3);
    @(negedge Clk);
    check("wrap_pc", {22'd0, PC2}, 32'd0);
    check("wrap_ack", {31'd0, Ack2}, 32'd1);
    check("wrap_cnt", {16'd0, CycleCount2}, 32'd2);
    check("other_unit_waiting", {22'd0, IMemAddr}, 32'h040);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
